// File: rtl/sr_lsu_pkg.sv
// sr_lsu_pkg: shared encodings for the load/store unit
package sr_lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_MISAL = 2'b01;
    localparam logic [1:0] F_RANGE = 2'b10;
    localparam logic [1:0] F_SIZE  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SZ_BYTE ? 3'd1 : size == SZ_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/sr_lsu_check.sv
// sr_lsu_check: classifies a request (size > alignment > range) and decodes size strobes
module sr_lsu_check
    import sr_lsu_pkg::*;
#(
    parameter int DEPTH            = 256,
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic [1:0]  fault,
    output logic        byte_w,
    output logic        half_w,
    output logic        word_w
);
    logic misal;
    logic range;

    assign byte_w = size == SZ_BYTE;
    assign half_w = size == SZ_HALF;
    assign word_w = size == SZ_WORD;
    assign misal  = !ALLOW_MISALIGNED && ((half_w && addr[0]) || (word_w && addr[1:0] != 2'b00));
    // 33-bit sum so addresses near the top of the space cannot wrap into range
    assign range  = ({1'b0, addr} + 33'(size_bytes(size))) > 33'(DEPTH);
    assign fault  = size == SZ_BAD ? F_SIZE : misal ? F_MISAL : range ? F_RANGE : F_NONE;
endmodule

// File: rtl/sr_lsu.sv
// sr_lsu: single-outstanding load/store unit driving the sr_mem strobe interface
module sr_lsu
    import sr_lsu_pkg::*;
#(
    parameter int DEPTH            = 256,
    parameter int WAIT_CYCLES      = 0,
    parameter bit ALLOW_MISALIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_sign,
    output logic        mem_byte_w,
    output logic        mem_half_w,
    output logic        mem_word_w,
    input  logic [31:0] mem_rdata
);
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        l_we;
    logic        l_uns;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [2:0]  l_str;
    logic [1:0]  fault;
    logic        byte_w;
    logic        half_w;
    logic        word_w;

    sr_lsu_check #(
        .DEPTH(DEPTH),
        .ALLOW_MISALIGNED(ALLOW_MISALIGNED)
    ) u_check (
        .addr(req_addr),
        .size(req_size),
        .fault(fault),
        .byte_w(byte_w),
        .half_w(half_w),
        .word_w(word_w)
    );

    // mem_* are registered so they are high only during ACCESS and reset clears them at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= F_NONE;
            l_we       <= 1'b0;
            l_uns      <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_str      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_sign   <= 1'b0;
            mem_byte_w <= 1'b0;
            mem_half_w <= 1'b0;
            mem_word_w <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    l_we      <= req_we;
                    l_uns     <= req_unsigned;
                    l_addr    <= req_addr;
                    l_wdata   <= req_wdata;
                    l_str     <= {word_w, half_w, byte_w};
                    req_ready <= 1'b0;
                    if (fault != F_NONE) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_fault <= fault;
                        state      <= RESP;
                    end else if (WAIT_CYCLES > 0) begin
                        cnt   <= WAIT_LOAD;
                        state <= WAIT;
                    end else begin
                        mem_addr   <= req_addr;
                        mem_wdata  <= req_wdata;
                        mem_we     <= req_we;
                        mem_sign   <= ~req_unsigned;
                        mem_byte_w <= byte_w;
                        mem_half_w <= half_w;
                        mem_word_w <= word_w;
                        state      <= ACCESS;
                    end
                end
                WAIT: if (cnt == 8'd0) begin
                    mem_addr   <= l_addr;
                    mem_wdata  <= l_wdata;
                    mem_we     <= l_we;
                    mem_sign   <= ~l_uns;
                    mem_byte_w <= l_str[0];
                    mem_half_w <= l_str[1];
                    mem_word_w <= l_str[2];
                    state      <= ACCESS;
                end else begin
                    cnt <= cnt - 8'd1;
                end
                ACCESS: begin
                    resp_rdata <= l_we ? '0 : mem_rdata;
                    resp_fault <= F_NONE;
                    resp_valid <= 1'b1;
                    mem_addr   <= '0;
                    mem_wdata  <= '0;
                    mem_we     <= 1'b0;
                    mem_sign   <= 1'b0;
                    mem_byte_w <= 1'b0;
                    mem_half_w <= 1'b0;
                    mem_word_w <= 1'b0;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
